// File: rtl/conv1d_stream_engine_pkg.sv
// Shared types and width helpers for the 1-D streaming convolution engine.
package conv_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int COEF_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } conv_state_e;

  // ceil(log2(n)) but never narrower than one bit
  function automatic int min1_clog2(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Full-precision accumulator: product width plus growth for K terms
  function automatic int acc_w(input int dw, input int cw, input int k);
    return dw + cw + $clog2(k);
  endfunction

  function automatic int addr_w(input int k);
    return min1_clog2(k);
  endfunction

  // Result index runs 0..n-k
  function automatic int idx_w(input int n, input int k);
    return min1_clog2(n - k + 1);
  endfunction

  // Pixel counter runs 0..n-1
  function automatic int cnt_w(input int n);
    return min1_clog2(n);
  endfunction

endpackage

// File: rtl/conv1d_stream_engine_if.sv
// Pixel-in / result-out stream bundle for the convolution engine.
// Handshake: a beat transfers on a rising clk edge where valid && ready are
// both high; the source holds valid and its payload stable until that edge,
// and valid never depends combinationally on ready.
interface conv1d_stream_engine_if
  import conv_pkg::*;
#(
  parameter int N_PIX  = 32,
  parameter int K      = 3,
  parameter int DATA_W = DATA_W_DEF,
  parameter int COEF_W = COEF_W_DEF
);
  localparam int ACC_W = acc_w(DATA_W, COEF_W, K);
  localparam int IDX_W = idx_w(N_PIX, K);

  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;

  logic                     out_valid;
  logic                     out_ready;
  logic signed [ACC_W-1:0]  out_data;
  logic [IDX_W-1:0]         out_idx;
  logic                     out_last;

  // Upstream producer + downstream consumer side
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last
  );

  // Engine side
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last
  );
endinterface

// File: rtl/conv1d_stream_engine_dot_k.sv
// Combinational K-tap signed multiply-add; tap 0 pairs with window slot 0.
module conv_dot_k
  import conv_pkg::*;
#(
  parameter int K      = 3,
  parameter int DATA_W = DATA_W_DEF,
  parameter int COEF_W = COEF_W_DEF
) (
  input  logic signed [DATA_W-1:0]                    win [K],
  input  logic signed [COEF_W-1:0]                    wt  [K],
  output logic signed [acc_w(DATA_W, COEF_W, K)-1:0]  sum
);
  localparam int ACC_W = acc_w(DATA_W, COEF_W, K);

  // Sign-extend both operands to the accumulator width before multiplying
  always_comb begin
    sum = '0;
    for (int j = 0; j < K; j++) begin
      sum = sum + ACC_W'(win[j]) * ACC_W'(wt[j]);
    end
  end
endmodule

// File: rtl/conv1d_stream_engine.sv
// Streaming valid-mode 1-D convolution: one pixel in per cycle, one result
// per accepted pixel once the window is full, with programmable taps and
// optional ReLU. The result register has a one-cycle latency.
module conv1d_stream_engine
  import conv_pkg::*;
#(
  parameter int N_PIX  = 32,
  parameter int K      = 3,
  parameter int DATA_W = DATA_W_DEF,
  parameter int COEF_W = COEF_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     w_we,
  input  logic [addr_w(K)-1:0]     w_addr,
  input  logic signed [COEF_W-1:0] w_data,
  input  logic                     relu_en,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output conv_state_e              dbg_state,
  conv1d_stream_engine_if.slave    strm
);
  localparam int ACC_W = acc_w(DATA_W, COEF_W, K);
  localparam int IDX_W = idx_w(N_PIX, K);
  localparam int CNT_W = cnt_w(N_PIX);

  conv_state_e              state, state_nx;
  logic signed [COEF_W-1:0] wt     [K];
  logic signed [DATA_W-1:0] win    [K];
  logic signed [DATA_W-1:0] win_nx [K];
  logic [CNT_W-1:0]         pcnt;
  logic                     relu_q;
  logic signed [ACC_W-1:0]  dot;
  logic                     accept;
  logic                     produce;
  logic                     last_pix;
  logic                     last_hs;

  assign accept   = strm.in_valid && strm.in_ready;
  assign produce  = accept && (pcnt >= CNT_W'(K - 1));
  assign last_pix = (pcnt == CNT_W'(N_PIX - 1));
  assign last_hs  = strm.out_valid && strm.out_ready && strm.out_last;

  assign busy          = (state == RUN) || (state == DRAIN);
  assign done          = (state == DONE);
  assign dbg_state     = state;
  // A new pixel may enter only if its result has somewhere to go this edge
  assign strm.in_ready = (state == RUN) && (!strm.out_valid || strm.out_ready);

  // Window as it will look after the current pixel shifts in (newest high)
  always_comb begin
    for (int j = 0; j < K - 1; j++) begin
      win_nx[j] = win[j + 1];
    end
    win_nx[K-1] = strm.in_data;
  end

  conv_dot_k #(
    .K      (K),
    .DATA_W (DATA_W),
    .COEF_W (COEF_W)
  ) u_dot (
    .win (win_nx),
    .wt  (wt),
    .sum (dot)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (accept && last_pix) state_nx = DRAIN;
      DRAIN:   if (last_hs) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Tap storage: writable only while idle, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < K; j++) wt[j] <= '0;
    end else if (state == IDLE && w_we && int'(w_addr) < K) begin
      wt[w_addr] <= w_data;
    end
  end

  // Window, pixel counter and latched ReLU mode
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt   <= '0;
      relu_q <= 1'b0;
      for (int j = 0; j < K; j++) win[j] <= '0;
    end else if (state == IDLE && start) begin
      pcnt   <= '0;
      relu_q <= relu_en;
      for (int j = 0; j < K; j++) win[j] <= '0;
    end else if (accept) begin
      pcnt <= pcnt + CNT_W'(1);
      for (int j = 0; j < K; j++) win[j] <= win_nx[j];
    end
  end

  // Result register: reloads on a producing accept, else empties on handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      strm.out_valid <= 1'b0;
      strm.out_data  <= '0;
      strm.out_idx   <= '0;
      strm.out_last  <= 1'b0;
    end else if (produce) begin
      strm.out_valid <= 1'b1;
      strm.out_data  <= (relu_q && dot[ACC_W-1]) ? '0 : dot;
      strm.out_idx   <= IDX_W'(pcnt - CNT_W'(K - 1));
      strm.out_last  <= last_pix;
    end else if (strm.out_valid && strm.out_ready) begin
      strm.out_valid <= 1'b0;
    end
  end

endmodule
